videomixer_layers: RTL and testbench
====================================

# videomixer_layers

Parametrised N-layer PAL 576i pixel mixer, successor to the two-layer black-keyed mixer. It sits between the layer generators (overlay/character, graphics, disc video) and the RGB output encoder. Each pixel it keys and priority-selects up to four layers using a programmable key colour and per-layer enables. An optional fade-to/from-black stage steps once per field. Configuration is double-buffered on vsync so mid-field writes never tear.

## Interface
- CHANNEL_W, 6: bits per colour channel.
- LAYERS, 2: number of input layers, legal 2..4; layer 0 is highest priority, layer LAYERS-1 is the background.
- pixelClockX6  in  1  pixel clock ×6; sole clock.
- reset  in  1  one clock; reset is synchronous and active-high.
- pixelClockPhase  in  3  pixel phase 0..5; phase 0 is the pixel strobe.
- vsync  in  1  one-clock field-start pulse.
- layer_rgb  in  LAYERS*3*CHANNEL_W  flattened {R,G,B} per layer; layer 0 in the LSBs.
- layer_en  in  LAYERS  per-layer enable (shadow).
- key_rgb  in  3*CHANNEL_W  transparency key colour {R,G,B} (shadow).
- key_en  in  1  keying enable (shadow).
- fade_start  in  1  one-clock fade request.
- fade_dir  in  1  1 = fade in (towards full), 0 = fade out (towards black).
- fade_step  in  4  alpha increment per field, 0 treated as 1.
- red_out, green_out, blue_out  out  CHANNEL_W each  mixed pixel.
- pixel_valid  out  1  one-clock pulse when outputs update.
- fade_busy  out  1  high while a fade is in progress.

## Operation
- Shadow config: layer_en, key_rgb and key_en are copied to active registers on the clock where vsync=1. Reset values of the active registers: layer_en all 1, key_en 0, key_rgb 0.
- Stage A (clock where pixelClockPhase==0): register all layers. Per layer compute keep = active_en[i] && !(active_key_en && rgb==active_key).
- Stage B: select the lowest-index kept layer among 0..LAYERS-2.
  - If none is kept, use the background layer LAYERS-1. The background is never keyed, but it is gated by its enable.
  - If the background is disabled, output 0.
- Stage C: out = (mix × alpha) >> 4, truncating, with alpha 0..16 held in 5 bits. alpha=16 is exact passthrough; alpha=0 gives black. Product width is CHANNEL_W+5.
- Fade FSM states:
  - IDLE: fade_busy=0.
  - FADE_IN / FADE_OUT: fade_busy=1.
  - fade_start moves to FADE_IN or FADE_OUT according to fade_dir. Alpha starts from its current value.
  - On each vsync while fading, alpha += step in FADE_IN, saturating at 16; alpha −= step in FADE_OUT, saturating at 0. Return to IDLE on the vsync where the limit is reached.
- Simultaneous events and boundaries:
  - fade_start on the same clock as vsync: the new state is entered and no step is applied on that vsync.
  - fade_start during a fade: restart in the new direction from the current alpha.
  - Fade in already at 16, or fade out already at 0: completes on the next vsync with alpha unchanged.
  - vsync while IDLE: alpha unchanged.
- Reset (including mid-fade or mid-pipeline): all outputs 0, pixel_valid 0, alpha=16, state IDLE. All pipeline stage registers are cleared.

## Timing
- Strobe clock t (phase 0): Stage A captures at the end of t, B at t+1, C/output registers at t+2.
- New output is visible from clock t+3 and held for the remaining clocks of the 6-clock pixel period. Latency is 3 clocks; one pixel per 6 clocks.
- pixel_valid is high for exactly one clock, aligned with the output update.
- Config and alpha changes at vsync affect pixels whose strobe is at or after the clock following vsync.
- Inputs that change on non-zero phases are ignored.

## Configuration
- VIDEOMIXER_FADE_EN defined: fade FSM and Stage C multiplier are present, behaving as described above.
- Not defined:
  - Stage C is a plain register, so latency is still 3 clocks.
  - alpha is fixed at 16; fade_busy is tied 0.
  - fade_start, fade_dir and fade_step are ignored.

## Structure
- Shared package videomixer_pkg holds:
  - ALPHA_W=5 and ALPHA_ONE=16;
  - the fade state encoding (IDLE, FADE_IN, FADE_OUT);
  - the default CHANNEL_W=6.
- One sub-module, videomixer_fade: the fade FSM and alpha register (inputs vsync, fade_start, fade_dir, fade_step; outputs alpha, fade_busy). It is instantiated only under VIDEOMIXER_FADE_EN.

## Test plan
- Priority keying: LAYERS=3, key_en=1, key=0, layer0=0, layer1=0x15/0x2A/0x3F, bg=0x01 → output 0x15/0x2A/0x3F at t+3, with pixel_valid a single pulse.
- Background fallback: layers 0 and 1 both equal the key, bg=0x20/0x10/0x08 → bg is output. Then clear layer_en[2] in shadow and pulse vsync → output 0 from the next pixel.
- Shadow tearing: change key_rgb mid-field with no vsync → keying result unchanged until after the next vsync.
- Fade: fade_start with dir=0, step=5 → alpha 11, 6, 1, 0 over four vsyncs; fade_busy drops on the fourth. An input of 0x3F gives 0x2B, 0x17, 0x03, 0x00.
- Corner cases: fade_start coincident with vsync → no step on that vsync. Reset asserted mid-fade at alpha=6 → outputs 0, alpha=16, IDLE on the next clock.
- Build without VIDEOMIXER_FADE_EN: fade_start ignored, fade_busy=0, latency still 3 clocks.

Source files
------------

// File: rtl/videomixer_pkg.sv
// videomixer_pkg: shared widths, alpha unity and fade state encoding
// for the keyed layer mixer.
package videomixer_pkg;
   localparam int ALPHA_W = 5;
   localparam logic [ALPHA_W-1:0] ALPHA_ONE = 5'd16;
   localparam int CHANNEL_W_DEFAULT = 6;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FADE_IN  = 2'd1,
      FADE_OUT = 2'd2
   } fade_state_t;
endpackage

// File: rtl/videomixer_fade.sv
// videomixer_fade: per-field fade FSM, alpha steps once per vsync
// and saturates at black or full scale.
module videomixer_fade
   import videomixer_pkg::*;
(
   input  logic               pixelClockX6,
   input  logic               reset,
   input  logic               vsync,
   input  logic               fade_start,
   input  logic               fade_dir,
   input  logic [3:0]         fade_step,
   output logic [ALPHA_W-1:0] alpha,
   output logic               fade_busy
);
   fade_state_t state, state_nx;
   logic [ALPHA_W-1:0] alpha_nx;
   logic [ALPHA_W:0] step;
   logic [ALPHA_W:0] sum;

   always_ff @(posedge pixelClockX6) begin
      if (reset) begin
         state <= IDLE;
         alpha <= ALPHA_ONE;
      end else begin
         state <= state_nx;
         alpha <= alpha_nx;
      end
   end

   always_comb begin
      state_nx = state;
      alpha_nx = alpha;
      step = (fade_step == 4'd0) ? 6'd1 : {2'b00, fade_step};
      sum = {1'b0, alpha} + step;
      fade_busy = (state != IDLE);
      // A new request wins over a coincident vsync step
      if (fade_start) begin
         state_nx = fade_dir ? FADE_IN : FADE_OUT;
      end else if (vsync) begin
         unique case (state)
            FADE_IN: begin
               if (sum >= {1'b0, ALPHA_ONE}) begin
                  alpha_nx = ALPHA_ONE;
                  state_nx = IDLE;
               end else begin
                  alpha_nx = sum[ALPHA_W-1:0];
               end
            end
            FADE_OUT: begin
               if ({1'b0, alpha} <= step) begin
                  alpha_nx = '0;
                  state_nx = IDLE;
               end else begin
                  alpha_nx = alpha - step[ALPHA_W-1:0];
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/videomixer_layers.sv
// videomixer_layers: N-layer keyed priority mixer, 3-clock pipeline.
// Define VIDEOMIXER_FADE_EN to build the fade FSM and alpha multiplier.
module videomixer_layers
   import videomixer_pkg::*;
#(
   parameter int CHANNEL_W = CHANNEL_W_DEFAULT,
   parameter int LAYERS    = 2
) (
   input  logic                          pixelClockX6,
   input  logic                          reset,
   input  logic [2:0]                    pixelClockPhase,
   input  logic                          vsync,
   input  logic [LAYERS*3*CHANNEL_W-1:0] layer_rgb,
   input  logic [LAYERS-1:0]             layer_en,
   input  logic [3*CHANNEL_W-1:0]        key_rgb,
   input  logic                          key_en,
   input  logic                          fade_start,
   input  logic                          fade_dir,
   input  logic [3:0]                    fade_step,
   output logic [CHANNEL_W-1:0]          red_out,
   output logic [CHANNEL_W-1:0]          green_out,
   output logic [CHANNEL_W-1:0]          blue_out,
   output logic                          pixel_valid,
   output logic                          fade_busy
);
   localparam int PIX_W  = 3*CHANNEL_W;
   localparam int PROD_W = CHANNEL_W + ALPHA_W;

   logic [LAYERS-1:0] act_en;
   logic [PIX_W-1:0]  act_key;
   logic              act_key_en;
   logic              strobe;
   logic [PIX_W-1:0]  in_pix [LAYERS];
   logic [LAYERS-1:0] in_keep;
   logic [PIX_W-1:0]  a_pix [LAYERS];
   logic [LAYERS-1:0] a_keep;
   logic              a_vld;
   logic              b_vld;
   logic [PIX_W-1:0]  sel;
   logic [PIX_W-1:0]  b_pix;
   logic [PIX_W-1:0]  c_pix;

   assign strobe = (pixelClockPhase == 3'd0);

   always_ff @(posedge pixelClockX6) begin
      if (reset) begin
         act_en     <= '1;
         act_key    <= '0;
         act_key_en <= 1'b0;
      end else if (vsync) begin
         act_en     <= layer_en;
         act_key    <= key_rgb;
         act_key_en <= key_en;
      end
   end

   // Background is never keyed, only gated by its enable
   always_comb begin
      in_keep = '0;
      for (int i = 0; i < LAYERS; i++) begin
         in_pix[i]  = layer_rgb[i*PIX_W +: PIX_W];
         in_keep[i] = act_en[i] && !(act_key_en && in_pix[i] == act_key);
      end
      in_keep[LAYERS-1] = act_en[LAYERS-1];
   end

   always_ff @(posedge pixelClockX6) begin
      if (reset) begin
         a_vld  <= 1'b0;
         a_keep <= '0;
         for (int i = 0; i < LAYERS; i++) a_pix[i] <= '0;
      end else begin
         a_vld <= strobe;
         if (strobe) begin
            a_keep <= in_keep;
            for (int i = 0; i < LAYERS; i++) a_pix[i] <= in_pix[i];
         end
      end
   end

   always_comb begin
      sel = a_keep[LAYERS-1] ? a_pix[LAYERS-1] : '0;
      for (int i = LAYERS-2; i >= 0; i--) begin
         if (a_keep[i]) sel = a_pix[i];
      end
   end

   always_ff @(posedge pixelClockX6) begin
      if (reset) begin
         b_vld <= 1'b0;
         b_pix <= '0;
      end else begin
         b_vld <= a_vld;
         if (a_vld) b_pix <= sel;
      end
   end

`ifdef VIDEOMIXER_FADE_EN
   logic [ALPHA_W-1:0] alpha;
   logic [ALPHA_W-1:0] a_alpha;
   logic [ALPHA_W-1:0] b_alpha;

   videomixer_fade u_fade (
      .pixelClockX6 (pixelClockX6),
      .reset        (reset),
      .vsync        (vsync),
      .fade_start   (fade_start),
      .fade_dir     (fade_dir),
      .fade_step    (fade_step),
      .alpha        (alpha),
      .fade_busy    (fade_busy)
   );

   function automatic logic [CHANNEL_W-1:0] scale(
      input logic [CHANNEL_W-1:0] c,
      input logic [ALPHA_W-1:0]   a
   );
      return CHANNEL_W'((PROD_W'(c) * PROD_W'(a)) >> 4);
   endfunction

   // Alpha travels with its pixel so a vsync mid-pipeline cannot split it
   always_ff @(posedge pixelClockX6) begin
      if (reset) begin
         a_alpha <= '0;
         b_alpha <= '0;
      end else begin
         if (strobe) a_alpha <= alpha;
         if (a_vld) b_alpha <= a_alpha;
      end
   end

   always_comb begin
      c_pix = {scale(b_pix[PIX_W-1 -: CHANNEL_W], b_alpha),
               scale(b_pix[2*CHANNEL_W-1 -: CHANNEL_W], b_alpha),
               scale(b_pix[CHANNEL_W-1:0], b_alpha)};
   end
`else
   logic fade_unused;
   assign fade_unused = ^{fade_start, fade_dir, fade_step};
   assign fade_busy   = 1'b0;
   assign c_pix       = b_pix;
`endif

   always_ff @(posedge pixelClockX6) begin
      if (reset) begin
         red_out     <= '0;
         green_out   <= '0;
         blue_out    <= '0;
         pixel_valid <= 1'b0;
      end else begin
         pixel_valid <= b_vld;
         if (b_vld) {red_out, green_out, blue_out} <= c_pix;
      end
   end
endmodule

// File: tb/tb_videomixer_layers.sv
// tb_videomixer_layers: directed vectors with a per-cycle reference model
// of the 3-layer mixer; literal checks pin the model.
module tb_videomixer_layers;
`ifdef VIDEOMIXER_FADE_EN
   localparam bit FADE = 1'b1;
`else
   localparam bit FADE = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [2:0]  phase = 3'd0;
   logic        vsync = 1'b0;
   logic [53:0] layer_rgb = '0;
   logic [2:0]  layer_en = 3'b111;
   logic [17:0] key_rgb = '0;
   logic        key_en = 1'b0;
   logic        fade_start = 1'b0;
   logic        fade_dir = 1'b0;
   logic [3:0]  fade_step = 4'd0;
   logic [5:0]  red_out, green_out, blue_out;
   logic        pixel_valid, fade_busy;

   int n_chk = 0;
   int n_pass = 0;

   videomixer_layers #(.CHANNEL_W(6), .LAYERS(3)) dut (
      .pixelClockX6    (clk),
      .reset           (reset),
      .pixelClockPhase (phase),
      .vsync           (vsync),
      .layer_rgb       (layer_rgb),
      .layer_en        (layer_en),
      .key_rgb         (key_rgb),
      .key_en          (key_en),
      .fade_start      (fade_start),
      .fade_dir        (fade_dir),
      .fade_step       (fade_step),
      .red_out         (red_out),
      .green_out       (green_out),
      .blue_out        (blue_out),
      .pixel_valid     (pixel_valid),
      .fade_busy       (fade_busy)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [17:0] rgb(input int r, input int g, input int b);
      return {r[5:0], g[5:0], b[5:0]};
   endfunction

   // Reference model: a pixel sampled on a phase-0 edge appears two edges later
   typedef struct packed {
      int          due;
      logic [17:0] pix;
   } exp_t;

   exp_t        q[$];
   int          edge_n = 0;
   bit          m_live = 1'b0;
   logic [17:0] m_out = '0;
   bit          m_valid = 1'b0;
   int          m_alpha = 16;
   int          m_state = 0;
   logic [2:0]  m_en = 3'b111;
   logic [17:0] m_key = '0;
   bit          m_key_en = 1'b0;

   initial forever begin
      logic [17:0] l [3];
      logic [17:0] s;
      bit          found;
      int          st;
      exp_t        e;
      @(posedge clk);
      edge_n++;
      if (reset) begin
         q.delete();
         m_out = '0;
         m_valid = 1'b0;
         m_alpha = 16;
         m_state = 0;
         m_en = 3'b111;
         m_key = '0;
         m_key_en = 1'b0;
         m_live = 1'b1;
      end else begin
         if (phase == 3'd0) begin
            for (int i = 0; i < 3; i++) l[i] = layer_rgb[i*18 +: 18];
            s = '0;
            found = 1'b0;
            for (int i = 0; i < 2; i++) begin
               if (!found && m_en[i] && !(m_key_en && l[i] == m_key)) begin
                  s = l[i];
                  found = 1'b1;
               end
            end
            if (!found && m_en[2]) s = l[2];
            e.due = edge_n + 2;
            e.pix = rgb(int'(s[17:12]) * m_alpha / 16,
                        int'(s[11:6]) * m_alpha / 16,
                        int'(s[5:0]) * m_alpha / 16);
            q.push_back(e);
         end
         if (FADE) begin
            st = (fade_step == 4'd0) ? 1 : int'(fade_step);
            if (fade_start) begin
               m_state = fade_dir ? 1 : 2;
            end else if (vsync && m_state == 1) begin
               m_alpha = m_alpha + st;
               if (m_alpha >= 16) begin
                  m_alpha = 16;
                  m_state = 0;
               end
            end else if (vsync && m_state == 2) begin
               m_alpha = m_alpha - st;
               if (m_alpha <= 0) begin
                  m_alpha = 0;
                  m_state = 0;
               end
            end
         end
         if (vsync) begin
            m_en = layer_en;
            m_key = key_rgb;
            m_key_en = key_en;
         end
         m_valid = 1'b0;
         if (q.size() > 0 && q[0].due == edge_n) begin
            m_out = q[0].pix;
            m_valid = 1'b1;
            void'(q.pop_front());
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (m_live) begin
         chk("model_valid", pixel_valid, m_valid);
         chk("model_rgb", {red_out, green_out, blue_out}, m_out);
         chk("model_busy", fade_busy, m_state != 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      phase = (phase == 3'd5) ? 3'd0 : phase + 3'd1;
      vsync = 1'b0;
      fade_start = 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic pix(input int n);
      run(6*n);
   endtask

   task automatic vs();
      vsync = 1'b1;
      tick();
   endtask

   function automatic logic [17:0] outv();
      return {red_out, green_out, blue_out};
   endfunction

   int fexp [4] = '{32'h2B, 32'h17, 32'h03, 32'h00};

   initial begin
      run(3);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_rgb", outv(), 0);
      chk("rst_valid", pixel_valid, 0);
      chk("rst_busy", fade_busy, 0);

      key_rgb = '0;
      key_en = 1'b1;
      layer_en = 3'b111;
      vs();
      layer_rgb = {rgb(1, 1, 1), rgb('h15, 'h2A, 'h3F), rgb(0, 0, 0)};
      pix(2);
      @(negedge clk);
      chk("prio", outv(), rgb('h15, 'h2A, 'h3F));

      while (phase != 3'd0) tick();
      layer_rgb[35:18] = rgb('h2A, 'h15, 'h01);
      tick();
      tick();
      @(negedge clk);
      chk("lat_hold", outv(), rgb('h15, 'h2A, 'h3F));
      chk("lat_v0", pixel_valid, 0);
      tick();
      @(negedge clk);
      chk("lat_new", outv(), rgb('h2A, 'h15, 'h01));
      chk("lat_v1", pixel_valid, 1);

      layer_rgb = {rgb('h20, 'h10, 'h08), rgb(0, 0, 0), rgb(0, 0, 0)};
      pix(2);
      @(negedge clk);
      chk("bg", outv(), rgb('h20, 'h10, 'h08));
      layer_en = 3'b011;
      pix(2);
      @(negedge clk);
      chk("bg_shadow", outv(), rgb('h20, 'h10, 'h08));
      vs();
      pix(2);
      @(negedge clk);
      chk("bg_off", outv(), 0);

      layer_en = 3'b111;
      vs();
      layer_rgb = {rgb(1, 1, 1), rgb('h11, 'h22, 'h33), rgb('h0A, 'h0A, 'h0A)};
      pix(2);
      @(negedge clk);
      chk("tear_pre", outv(), rgb('h0A, 'h0A, 'h0A));
      key_rgb = rgb('h0A, 'h0A, 'h0A);
      pix(2);
      @(negedge clk);
      chk("tear_hold", outv(), rgb('h0A, 'h0A, 'h0A));
      vs();
      pix(2);
      @(negedge clk);
      chk("tear_post", outv(), rgb('h11, 'h22, 'h33));

      while (phase != 3'd3) tick();
      layer_rgb[35:18] = rgb('h3F, 0, 0);
      tick();
      layer_rgb[35:18] = rgb('h11, 'h22, 'h33);
      pix(2);
      @(negedge clk);
      chk("glitch", outv(), rgb('h11, 'h22, 'h33));

      key_en = 1'b0;
      vs();
      layer_rgb[17:0] = rgb('h3F, 'h3F, 'h3F);
      pix(2);
      @(negedge clk);
      chk("full", outv(), rgb('h3F, 'h3F, 'h3F));

      fade_dir = 1'b0;
      fade_step = 4'd5;
      fade_start = 1'b1;
      tick();
      pix(1);
      @(negedge clk);
      chk("fade_busy", fade_busy, FADE);
      for (int k = 0; k < 4; k++) begin
         vs();
         pix(2);
         @(negedge clk);
         chk($sformatf("fade_out%0d", k), outv(),
             FADE ? rgb(fexp[k], fexp[k], fexp[k]) : rgb('h3F, 'h3F, 'h3F));
         chk($sformatf("fade_busy%0d", k), fade_busy, FADE && k < 3);
      end

      fade_dir = 1'b1;
      fade_step = 4'd0;
      fade_start = 1'b1;
      vsync = 1'b1;
      tick();
      pix(2);
      @(negedge clk);
      chk("coinc_hold", outv(), FADE ? 0 : rgb('h3F, 'h3F, 'h3F));
      chk("coinc_busy", fade_busy, FADE);
      vs();
      pix(2);
      @(negedge clk);
      chk("step0", outv(), FADE ? rgb(3, 3, 3) : rgb('h3F, 'h3F, 'h3F));

      fade_step = 4'd5;
      fade_start = 1'b1;
      tick();
      vs();
      pix(2);
      @(negedge clk);
      chk("alpha6", outv(), FADE ? rgb('h17, 'h17, 'h17) : rgb('h3F, 'h3F, 'h3F));

      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rst2_rgb", outv(), 0);
      chk("rst2_valid", pixel_valid, 0);
      chk("rst2_busy", fade_busy, 0);
      pix(2);
      @(negedge clk);
      chk("post_rst", outv(), rgb('h3F, 'h3F, 'h3F));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
